// File: rtl/prm_edge_mask_accum.sv
// Collects per-edge obstacle-check hits into a sticky bitmap over one frame, then
// drains it as WORD_W-bit words while counting the blocked edges.
module prm_edge_mask_accum #(
  parameter int NUM_EDGE = 64,
  parameter int WORD_W   = 16,
  localparam int NWORD   = NUM_EDGE / WORD_W,
  localparam int IDX_W   = (NWORD > 1) ? $clog2(NWORD) : 1,
  localparam int CNT_W   = $clog2(NUM_EDGE + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [NUM_EDGE-1:0] in_mask,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                done,
  output logic [CNT_W-1:0]    blocked_cnt,
  output logic [15:0]         obs_cnt
);

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_reg;
  logic [NUM_EDGE-1:0] acc_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    run_cnt_reg;
  logic [CNT_W-1:0]    blocked_cnt_reg;
  logic [15:0]         obs_cnt_reg;
  logic                first_reg;

  logic [WORD_W-1:0]   word_arr [NWORD];
  logic [CNT_W-1:0]    word_pop;
  logic [CNT_W-1:0]    run_cnt_next;
  logic                last_word;

  genvar gi;
  generate
    for (gi = 0; gi < NWORD; gi++) begin : g_word
      assign word_arr[gi] = acc_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign in_ready    = (state_reg == ST_ACC);
  assign out_valid   = (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);
  assign out_data    = word_arr[idx_reg];
  assign out_idx     = idx_reg;
  assign last_word   = (idx_reg == IDX_W'(NWORD - 1));
  assign out_last    = last_word;
  assign blocked_cnt = blocked_cnt_reg;
  assign obs_cnt     = obs_cnt_reg;

  always_comb begin
    word_pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      word_pop = word_pop + CNT_W'(out_data[i]);
    end
  end

  // Running total cannot exceed NUM_EDGE, so CNT_W never overflows.
  assign run_cnt_next = run_cnt_reg + word_pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_ACC;
      acc_reg         <= '0;
      idx_reg         <= '0;
      run_cnt_reg     <= '0;
      blocked_cnt_reg <= '0;
      obs_cnt_reg     <= '0;
      first_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (in_valid) begin
            if (first_reg) begin
              acc_reg         <= in_mask;
              obs_cnt_reg     <= 16'd1;
              blocked_cnt_reg <= '0;
              first_reg       <= 1'b0;
            end else begin
              acc_reg <= acc_reg | in_mask;
              if (obs_cnt_reg != 16'hFFFF) obs_cnt_reg <= obs_cnt_reg + 16'd1;
            end
            if (in_last) begin
              state_reg   <= ST_DRAIN;
              idx_reg     <= '0;
              run_cnt_reg <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            run_cnt_reg <= run_cnt_next;
            if (last_word) begin
              state_reg       <= ST_DONE;
              blocked_cnt_reg <= run_cnt_next;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          // acc_reg is kept; the next frame's first beat overwrites it.
          first_reg <= 1'b1;
          state_reg <= ST_ACC;
        end
        default: state_reg <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum; inputs change and outputs are sampled
// on the falling edge, so each negedge sees the state left by the prior posedge.
module tb_prm_edge_mask_accum;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_last;
  logic [63:0] in_mask;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        done;
  logic [6:0]  blocked_cnt;
  logic [15:0] obs_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  prm_edge_mask_accum #(.NUM_EDGE(64), .WORD_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_last(in_last), .in_mask(in_mask), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done),
    .blocked_cnt(blocked_cnt), .obs_cnt(obs_cnt)
  );

  // Presents one beat from a falling edge and holds it until it is accepted.
  task automatic send_beat(input logic [63:0] mask, input logic last);
    logic taken;
    taken = 1'b0;
    in_valid = 1'b1; in_mask = mask; in_last = last;
    for (int t = 0; t < 20; t++) begin
      taken = in_ready;
      @(negedge CLK);
      if (taken) break;
    end
    in_valid = 1'b0; in_last = 1'b0; in_mask = '0;
    n_cmp++;
    if (!taken) begin
      n_bad++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
    end
  endtask

  // Collects a full drain with out_ready=1; word k lands in w_cat[k*16 +: 16].
  task automatic drain_all(output logic [63:0] w_cat, output logic [7:0] ix_cat,
                           output logic [3:0] lst, output int hs,
                           output bit got_done, output int gap);
    int last_cyc;
    w_cat = '0; ix_cat = '0; lst = '0; hs = 0; got_done = 0; gap = 0; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1; gap = cyc - last_cyc;
        $display("drain done  blocked_cnt=%0d obs_cnt=%0d", blocked_cnt, obs_cnt);
      end else if (out_valid && out_ready) begin
        if (hs < 4) begin
          w_cat[hs*16 +: 16] = out_data;
          ix_cat[hs*2 +: 2]  = out_idx;
          lst[hs]            = out_last;
        end
        $display("drain word  idx=%0d data=%h last=%0b", out_idx, out_data, out_last);
        hs++; last_cyc = cyc;
      end
      if (!got_done) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 0; in_last = 0; in_mask = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, done} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags: {in_ready,out_valid,done}=%b required 100", {in_ready, out_valid, done});
    end
    n_cmp++;
    if (blocked_cnt !== 7'd0 || obs_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_counts: blocked=%0d obs=%0d required 0/0", blocked_cnt, obs_cnt);
    end
  endtask

  task automatic test_frame();
    logic [63:0] w; logic [7:0] ix; logic [3:0] lst; int hs; bit gd; int gap;
    send_beat(64'h0000_0000_0000_0001, 1'b0);
    send_beat(64'h8000_0000_0000_0000, 1'b0);
    send_beat(64'h0000_0001_0000_0000, 1'b1);
    drain_all(w, ix, lst, hs, gd, gap);
    n_cmp++;
    if (w !== 64'h8000_0001_0000_0001 || hs !== 4) begin
      n_bad++; $display("FAIL frame_words: words=%h hs=%0d required 8000000100000001/4", w, hs);
    end
    n_cmp++;
    if (ix !== 8'hE4 || lst !== 4'b1000) begin
      n_bad++; $display("FAIL frame_idx_last: idx=%h last=%b required e4/1000", ix, lst);
    end
    n_cmp++;
    if (!gd || gap !== 1) begin
      n_bad++; $display("FAIL frame_done_timing: done_seen=%0b gap=%0d required 1/1", gd, gap);
    end
    n_cmp++;
    if (blocked_cnt !== 7'd3 || obs_cnt !== 16'd3) begin
      n_bad++; $display("FAIL frame_counts: blocked=%0d obs=%0d required 3/3", blocked_cnt, obs_cnt);
    end
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL frame_done_pulse: done=%0b in_ready=%0b required 0/1", done, in_ready);
    end
  endtask

  // All-ones drain under backpressure, with the next frame's beat held during it.
  task automatic test_backpressure();
    int stall_bad, ir_bad, idx_bad, hs; bit got; logic taken;
    logic [63:0] w; logic [7:0] ix; logic [3:0] lst; int hs2; bit gd; int gap;
    out_ready = 1'b0;
    send_beat('1, 1'b1);
    in_valid = 1'b1; in_mask = 64'h0000_0000_0000_00FF; in_last = 1'b1;
    stall_bad = 0;
    for (int t = 0; t < 5; t++) begin
      if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_idx !== 2'd0 || in_ready !== 1'b0)
        stall_bad++;
      @(negedge CLK);
    end
    n_cmp++;
    if (stall_bad != 0) begin
      n_bad++; $display("FAIL bp_stall_hold: bad_cycles=%0d required 0", stall_bad);
    end
    hs = 0; ir_bad = 0; idx_bad = 0; got = 0;
    for (int t = 0; t < 30; t++) begin
      if (done) begin got = 1; break; end
      out_ready = (t % 2 == 0);
      if (in_ready !== 1'b0) ir_bad++;
      if (out_valid !== 1'b1 || out_idx !== hs[1:0] || out_data !== 16'hFFFF) idx_bad++;
      if (out_ready) begin
        $display("bp word     idx=%0d data=%h", out_idx, out_data);
        hs++;
      end
      @(negedge CLK);
    end
    out_ready = 1'b1;
    n_cmp++;
    if (!got || hs != 4) begin
      n_bad++; $display("FAIL bp_handshakes: done_seen=%0b hs=%0d required 1/4", got, hs);
    end
    n_cmp++;
    if (ir_bad != 0 || idx_bad != 0) begin
      n_bad++; $display("FAIL bp_drain_outputs: in_ready_bad=%0d word_bad=%0d required 0/0", ir_bad, idx_bad);
    end
    n_cmp++;
    if (blocked_cnt !== 7'd64) begin
      n_bad++; $display("FAIL bp_blocked: blocked=%0d required 64", blocked_cnt);
    end
    taken = 1'b0;
    for (int t = 0; t < 5; t++) begin
      taken = in_ready;
      @(negedge CLK);
      if (taken) break;
    end
    in_valid = 1'b0; in_last = 1'b0; in_mask = '0;
    n_cmp++;
    if (!taken || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL held_beat_taken: taken=%0b out_valid=%0b required 1/1", taken, out_valid);
    end
    drain_all(w, ix, lst, hs2, gd, gap);
    n_cmp++;
    if (w !== 64'h0000_0000_0000_00FF || !gd || blocked_cnt !== 7'd8 || obs_cnt !== 16'd1) begin
      n_bad++; $display("FAIL held_frame: words=%h done=%0b blocked=%0d obs=%0d required 00ff/1/8/1",
                        w, gd, blocked_cnt, obs_cnt);
    end
  endtask

  task automatic test_second_frame();
    logic [63:0] w; logic [7:0] ix; logic [3:0] lst; int hs; bit gd; int gap;
    @(negedge CLK);
    n_cmp++;
    if (blocked_cnt !== 7'd8) begin
      n_bad++; $display("FAIL second_pre_blocked: blocked=%0d required 8", blocked_cnt);
    end
    send_beat('0, 1'b1);
    n_cmp++;
    if (blocked_cnt !== 7'd0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL second_clear: blocked=%0d out_valid=%0b required 0/1", blocked_cnt, out_valid);
    end
    drain_all(w, ix, lst, hs, gd, gap);
    n_cmp++;
    if (w !== 64'h0 || hs != 4 || !gd) begin
      n_bad++; $display("FAIL second_words: words=%h hs=%0d done=%0b required 0/4/1", w, hs, gd);
    end
    n_cmp++;
    if (blocked_cnt !== 7'd0 || obs_cnt !== 16'd1) begin
      n_bad++; $display("FAIL second_counts: blocked=%0d obs=%0d required 0/1", blocked_cnt, obs_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] w; logic [7:0] ix; logic [3:0] lst; int hs; bit gd; int gap; int done_seen;
    @(negedge CLK);
    out_ready = 1'b1;
    send_beat(64'h0000_0000_0003_0002, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, done} !== 3'b010 || obs_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_mid_state: {out_valid,in_ready,done}=%b obs=%0d required 010/0",
                        {out_valid, in_ready, done}, obs_cnt);
    end
    done_seen = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK);
      if (done !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_bad++; $display("FAIL rst_mid_no_done: done_cycles=%0d required 0", done_seen);
    end
    send_beat(64'h1, 1'b1);
    drain_all(w, ix, lst, hs, gd, gap);
    n_cmp++;
    if (w !== 64'h1 || !gd || blocked_cnt !== 7'd1) begin
      n_bad++; $display("FAIL rst_mid_next_frame: words=%h done=%0b blocked=%0d required 1/1/1", w, gd, blocked_cnt);
    end
  endtask

  task automatic test_obs_saturation();
    int early;
    logic [63:0] w; logic [7:0] ix; logic [3:0] lst; int hs; bit gd; int gap;
    @(negedge CLK);
    early = 0;
    in_mask = '0;
    for (int i = 0; i < 70100; i++) begin
      if (i % 1000 == 500) begin
        in_valid = 1'b0; in_last = 1'b1;
      end else begin
        in_valid = 1'b1; in_last = 1'b0;
      end
      @(negedge CLK);
      if (out_valid !== 1'b0) early++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    $display("sat stream  obs_cnt=%h", obs_cnt);
    n_cmp++;
    if (early != 0) begin
      n_bad++; $display("FAIL sat_no_early_drain: early_cycles=%0d required 0", early);
    end
    n_cmp++;
    if (obs_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_obs_cnt: obs=%h required ffff", obs_cnt);
    end
    send_beat('0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
      n_bad++; $display("FAIL sat_drain_start: out_valid=%0b idx=%0d required 1/0", out_valid, out_idx);
    end
    drain_all(w, ix, lst, hs, gd, gap);
    n_cmp++;
    if (!gd || hs != 4 || obs_cnt !== 16'hFFFF || blocked_cnt !== 7'd0) begin
      n_bad++; $display("FAIL sat_drain: done=%0b hs=%0d obs=%h blocked=%0d required 1/4/ffff/0",
                        gd, hs, obs_cnt, blocked_cnt);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_frame();
    test_backpressure();
    test_second_frame();
    test_reset_mid_drain();
    test_obs_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
- Sits directly downstream of the bank of prm_oblgc_chk* obstacle-check blocks, one checker per roadmap edge.
- For each obstacle voxel code driven into the bank, it accepts the NUM_EDGE-wide vector of edge_mask bits.
- Over one obstacle frame it accumulates a sticky blocked-edge bitmap, then drains that bitmap as WORD_W-bit words over a valid/ready interface.
- While draining it counts the blocked edges and reports the count to the planner.

Parameters:
- NUM_EDGE, 64: number of edge checkers, which is the input vector width. Must be a multiple of WORD_W.
- WORD_W, 16: output word width.
- NWORD, NUM_EDGE/WORD_W (4): number of output words. Derived, not overridable.
- IDX_W, clog2(NWORD) (2): output word index width.
- CNT_W, clog2(NUM_EDGE+1) (7): blocked-edge count width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  in_mask holds the checker results for one obstacle code.
- in_last  in  1  marks the last obstacle code of the frame; qualified by in_valid.
- in_mask  in  NUM_EDGE  edge_mask bits; bit e comes from checker e.
- in_ready  out  1  the block accepts an input beat.
- out_valid  out  1  out_data holds a bitmap word.
- out_ready  in  1  the consumer takes the word.
- out_data  out  WORD_W  bitmap word; word k carries edges [k*WORD_W +: WORD_W].
- out_idx  out  IDX_W  index k of the current word.
- out_last  out  1  the current word is word NWORD-1.
- done  out  1  one-cycle pulse when the frame's drain completes.
- blocked_cnt  out  CNT_W  number of set bitmap bits; valid from done until the next frame's first beat.
- obs_cnt  out  16  beats accepted in the current or last frame; saturates at 16'hFFFF.

Behaviour:
- Reset, synchronous and active-high, sampled on the CLK rising edge:
  - state=ACC, acc=0, idx=0, blocked_cnt=0, obs_cnt=0.
  - out_valid=0, done=0, in_ready=1.
  - Reset mid-frame or mid-drain discards all partial results. No done pulse is generated.
- State ACC:
  - in_ready=1 and out_valid=0.
  - A beat is accepted on in_valid & in_ready. On an accepted beat:
    - acc <= acc | in_mask.
    - obs_cnt <= obs_cnt+1, saturating.
  - On the first beat of a frame, in place of the above:
    - acc <= in_mask and obs_cnt <= 1.
    - blocked_cnt <= 0.
    - The first-beat flag is set after reset and after done.
  - If the accepted beat has in_last=1, go to DRAIN with idx=0 and a running count of 0.
  - in_last with in_valid=0 is ignored.
- State DRAIN:
  - in_ready=0, out_valid=1.
  - out_data=acc[idx*WORD_W +: WORD_W], out_idx=idx, out_last=(idx==NWORD-1).
  - The first word is valid on the cycle after the in_last beat is accepted (1-cycle latency).
  - Handshake is out_valid & out_ready. On a handshake:
    - running count += popcount(out_data).
    - If idx<NWORD-1, idx++.
    - Otherwise go to DONE and load blocked_cnt with the final running count, including the last word.
  - While out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops before its handshake.
- State DONE, one cycle:
  - done=1, in_ready=0, out_valid=0.
  - Set the first-beat flag; go to ACC.
  - acc is retained until overwritten by the next frame's first beat.
- Arithmetic rules:
  - popcount is over WORD_W bits.
  - The running count is CNT_W wide and cannot overflow, since the maximum is NUM_EDGE.
  - obs_cnt saturates rather than wraps.
- Boundary conditions:
  - A single-beat frame (first beat carries in_last) is legal: the bitmap equals that one mask.
  - All-zero bitmap: all words drain; blocked_cnt=0 and done still pulses.
  - All-ones bitmap: blocked_cnt=NUM_EDGE.
  - in_valid held high during DRAIN or DONE is not accepted and is not lost: the upstream holds the beat because in_ready=0.

Test Plan:
- Reset then one frame, NUM_EDGE=64, WORD_W=16:
  - Stimulus: beats 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, then 64'h0000_0001_0000_0000 with in_last=1; out_ready tied to 1.
  - Required: words 0x0001, 0x0000, 0x0001, 0x8000 with idx 0..3 and out_last on idx 3.
  - Required: done one cycle after word 3; blocked_cnt=3, obs_cnt=3.
- Backpressure:
  - Stimulus: single-beat frame of all-ones; out_ready low for 5 cycles, then toggled 1/0.
  - Required: out_data stays 0xFFFF and out_idx stays stable while stalled; exactly 4 handshakes occur.
  - Required: blocked_cnt=64, in_ready=0 throughout the drain.
- Second frame independence:
  - Stimulus: a frame with bitmap 0x00FF, followed by a frame whose only beat is all-zero.
  - Required: the second drain emits four 0x0000 words; blocked_cnt=0 and obs_cnt=1; blocked_cnt clears on the first beat of the second frame.
- Reset mid-drain:
  - Stimulus: assert RST after word 1's handshake.
  - Required: next cycle out_valid=0, in_ready=1, obs_cnt=0 and no done pulse.
  - Required: a new single-beat frame of 64'h1 drains 0x0001,0,0,0 with blocked_cnt=1.
- obs_cnt saturation and ignored in_last:
  - Stimulus: 70000 beats of all-zero masks with in_last=0, plus isolated cycles of in_last=1 with in_valid=0; then an in_last beat.
  - Required: obs_cnt=16'hFFFF, no early drain, and the drain starts only after the valid in_last beat.
